pipe_ctrl_fsm: RTL

//  Y86-64 pipeline control unit, successor to the combinational hazard unit.

---
 rtl/y86_pkg.sv | 30 +++
 rtl/pipe_hazard_detect.sv | 34 +++
 rtl/pipe_ctrl_fsm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (icodes, register/status codes) and the pipeline control FSM states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard classification: load/use, mispredicted branch, ret in flight,
// and whether the instruction in M touches data memory. Zero latency, no state.
module pipe_hazard_detect
  import y86_pkg::*;
#(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4
) (
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic               e_Cnd,
  input  logic [ICODE_W-1:0] M_icode,
  output logic               lu_o,
  output logic               mp_o,
  output logic               ret_o,
  output logic               m_memop_o
);

  logic e_is_load;

  assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
  assign lu_o      = e_is_load && (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mp_o      = (E_icode == I_JXX) && !e_Cnd;
  assign ret_o     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

  assign m_memop_o = (M_icode == I_MRMOVQ) || (M_icode == I_RMMOVQ) ||
                     (M_icode == I_PUSHQ)  || (M_icode == I_POPQ)   ||
                     (M_icode == I_CALL)   || (M_icode == I_RET);

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Y86-64 pipeline control: stall/bubble/set_cc per stage, data-memory wait state, sticky halt.
// Outputs are combinational from state and inputs; PIPE_PERF_CNT_EN adds saturating perf counters.
module pipe_ctrl_fsm
  import y86_pkg::*;
#(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 2,
  parameter int MEM_LAT = 1
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic               e_Cnd,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [STAT_W-1:0]  W_stat,
  output logic               set_cc,
  output logic               F_stall,
  output logic               D_stall,
  output logic               E_stall,
  output logic               M_stall,
  output logic               W_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_bubble,
  output logic               halted
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);

  // Counter only needs to hold MEM_LAT-2; the entry cycle itself is the first stall.
  localparam int WCNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic lu, mp, ret, m_memop;
  logic w_exc, m_exc, mem_start, wait_busy, mem_stall;

  pipe_hazard_detect #(
    .ICODE_W (ICODE_W),
    .REG_W   (REG_W)
  ) u_hazard (
    .D_icode   (D_icode),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .E_icode   (E_icode),
    .E_dstM    (E_dstM),
    .e_Cnd     (e_Cnd),
    .M_icode   (M_icode),
    .lu_o      (lu),
    .mp_o      (mp),
    .ret_o     (ret),
    .m_memop_o (m_memop)
  );

  assign w_exc     = (W_stat != STAT_AOK);
  assign m_exc     = (m_stat != STAT_AOK);
  assign mem_start = (MEM_LAT > 1) && (state_q == ST_RUN) && m_memop;
  assign wait_busy = (state_q == ST_MEMWAIT) && (wait_cnt_q != '0);
  assign mem_stall = !w_exc && !m_exc && (mem_start || wait_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q != ST_HALTED) begin
      if (w_exc) begin
        state_d    = ST_HALTED;
        wait_cnt_d = '0;
      end else if (m_exc) begin
        // A faulting access abandons any pending wait.
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end else if (mem_start) begin
        state_d    = ST_MEMWAIT;
        wait_cnt_d = WAIT_INIT;
      end else if (wait_busy) begin
        state_d    = ST_MEMWAIT;
        wait_cnt_d = wait_cnt_q - WCNT_W'(1);
      end else begin
        state_d    = ST_RUN;
      end
    end
  end

  always_comb begin
    set_cc   = 1'b0;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    halted   = 1'b0;
    if (!rst_n) begin
      halted = 1'b0;
    end else if (state_q == ST_HALTED) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
      halted  = 1'b1;
    end else if (mem_stall) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_stall  = 1'b1;
      W_bubble = 1'b1;
    end else begin
      F_stall  = lu | ret;
      D_stall  = lu;
      D_bubble = mp | (ret & ~lu);
      E_bubble = mp | lu;
      if (w_exc) begin
        W_stall  = 1'b1;
        M_bubble = 1'b1;
      end else if (m_exc) begin
        M_bubble = 1'b1;
      end else begin
        set_cc = (E_icode == I_OPQ);
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt    <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if ((state_q != ST_HALTED) && (cyc_cnt != '1))
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (F_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((D_bubble || E_bubble) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
